// File: rtl/spi_cmd_framer.sv
// SPI (mode 0, MSB first) command framer: 4-byte opcode/arg_hi/arg_lo/checksum frames drive wave_sel, div_out, amp_out.
// Latency: outputs and *_upd change SYNC_STAGES+2 clk after cs rises at the pin; no backpressure, frames are applied as they complete.
module spi_cmd_framer #(
  parameter int          SYNC_STAGES    = 2,
  parameter int          TIMEOUT_CYCLES = 120000,
  parameter logic [15:0] DIV_RESET      = 16'd1,
  parameter logic [9:0]  AMP_RESET      = 10'h3FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        mosi,
  input  logic        cs,
  output logic [3:0]  wave_sel,
  output logic [15:0] div_out,
  output logic [9:0]  amp_out,
  output logic        wave_upd,
  output logic        div_upd,
  output logic        amp_upd,
  output logic [2:0]  err_flags
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    RX        = 2'd2,
    CHECK     = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic                   sclk_prev, cs_prev;
  logic [FW-1:0]          fill_cnt;
  logic                   filled;

  logic [31:0]   shreg;
  logic [5:0]    bit_cnt;
  logic          ovr;
  logic [TW-1:0] to_cnt;

  logic sclk_s, mosi_s, cs_s;
  logic sclk_rise, cs_rise, cs_fall;
  logic start, shift_en, ovr_en, timeout, check;

  logic [7:0]  opcode;
  logic [15:0] arg;
  logic        len_ok, csum_ok;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_fall   = ~cs_s & cs_prev;

  // The chain resets to "cs idle"; it only reflects the pin once refilled.
  assign filled = (fill_cnt == FW'(SYNC_STAGES));

  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
      fill_cnt  <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
      if (!filled) fill_cnt <= fill_cnt + FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= WAIT_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    shift_en = 1'b0;
    ovr_en   = 1'b0;
    timeout  = 1'b0;
    check    = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        if (filled && cs_s) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          start   = 1'b1;
          state_d = RX;
        end
      end
      RX: begin
        // cs release wins over a coincident spi_clk edge
        if (cs_rise) begin
          state_d = CHECK;
        end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
          state_d = WAIT_IDLE;
        end else if (sclk_rise && !cs_s) begin
          if (bit_cnt == 6'd32) ovr_en   = 1'b1;
          else                  shift_en = 1'b1;
        end
      end
      CHECK: begin
        check   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  assign opcode  = shreg[31:24];
  assign arg     = shreg[23:8];
  assign len_ok  = (bit_cnt == 6'd32) && !ovr;
  assign csum_ok = (shreg[7:0] == (shreg[31:24] ^ shreg[23:16] ^ shreg[15:8]));

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      ovr     <= 1'b0;
      to_cnt  <= '0;
    end else begin
      if (start) begin
        shreg   <= '0;
        bit_cnt <= '0;
        ovr     <= 1'b0;
        to_cnt  <= '0;
      end else if (state_q == RX) begin
        to_cnt <= to_cnt + TW'(1);
      end
      if (shift_en) begin
        shreg   <= {shreg[30:0], mosi_s};
        bit_cnt <= bit_cnt + 6'd1;
      end
      if (ovr_en) ovr <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wave_sel  <= 4'd0;
      div_out   <= DIV_RESET;
      amp_out   <= AMP_RESET;
      wave_upd  <= 1'b0;
      div_upd   <= 1'b0;
      amp_upd   <= 1'b0;
      err_flags <= 3'b000;
    end else begin
      wave_upd <= 1'b0;
      div_upd  <= 1'b0;
      amp_upd  <= 1'b0;
      if (timeout) err_flags[0] <= 1'b1;
      if (check) begin
        if (!len_ok) begin
          err_flags[0] <= 1'b1;
        end else if (!csum_ok) begin
          err_flags[1] <= 1'b1;
        end else begin
          case (opcode)
            8'h01: begin
              wave_sel  <= arg[3:0];
              wave_upd  <= 1'b1;
              err_flags <= 3'b000;
            end
            8'h02: begin
              // a divider of 0 would stall var_clk; clamp to 1
              div_out   <= (arg == 16'd0) ? 16'd1 : arg;
              div_upd   <= 1'b1;
              err_flags <= 3'b000;
            end
            8'h03: begin
              amp_out   <= arg[9:0];
              amp_upd   <= 1'b1;
              err_flags <= 3'b000;
            end
            default: err_flags[2] <= 1'b1;
          endcase
        end
      end
    end
  end

endmodule
